cmp_result_collector: RTL and testbench
=======================================

Name: cmp_result_collector

Overview:
- Downstream stage of the 32-bit signed/unsigned comparator.
- Tracks which operand pairs were issued and aligns each one with the comparator's registered flag outputs (eq/neq/grt/lss) after the comparator latency.
- Classifies each flag set into a 2-bit result code, checks flag consistency and buffers tagged results in a FIFO toward a ready/valid consumer.
- Back-pressures the operand source through credit-based issue_rdy so no result is ever dropped.

Parameters:
DEPTH, 8, result FIFO entries (power of two, >=2)
TAG_W, 4, width of issue tag carried alongside each comparison
CMP_LAT, 1, comparator latency in clk cycles from operands valid to flags valid (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
issue_vld  in  1  operand pair presented to comparator this cycle
issue_tag  in  TAG_W  tag of that operand pair
issue_rdy  out  1  collector can accept an issue this cycle
eq  in  1  comparator equal flag
neq  in  1  comparator not-equal flag
grt  in  1  comparator greater flag
lss  in  1  comparator less flag
out_vld  out  1  result at FIFO head valid
out_rdy  in  1  consumer accepts head
out_tag  out  TAG_W  tag of head result
out_code  out  2  00 EQ, 01 GRT, 10 LSS, 11 ERR
fifo_cnt  out  $clog2(DEPTH)+1  current FIFO occupancy
err_sticky  out  1  set on any ERR classification

Behaviour:
- Reset (async assert, sync release): pipeline valids, FIFO pointers, fifo_cnt and err_sticky go to 0; out_vld=0, out_tag=0, out_code=0; issue_rdy=1 after release.
- Issue accepted when issue_vld && issue_rdy. issue_vld while issue_rdy=0 is ignored; the source must hold the operands.
- Tag/valid delay pipe: CMP_LAT stages. On the cycle the last stage is valid, sample eq/neq/grt/lss and push {tag, code}.
- Classification, with flags in order {eq,neq,grt,lss}:
  - 1000 -> EQ
  - 0110 -> GRT
  - 0101 -> LSS
  - anything else -> ERR, and err_sticky set the following cycle.
- Credit: issue_rdy = (inflight + fifo_cnt) < DEPTH, computed combinationally from registered counts. Inflight counts valid stages in the delay pipe. The FIFO can therefore never overflow; a push into a full FIFO is impossible by construction. An assertion must flag it.
- FIFO is show-ahead: out_vld = fifo_cnt != 0, and out_tag/out_code are driven from the head entry.
- Pop when out_vld && out_rdy. Simultaneous push and pop leaves fifo_cnt unchanged. Pointers wrap modulo DEPTH.
- Latency:
  - Issue to push edge = CMP_LAT cycles.
  - Push to out_vld = 1 cycle, so an empty-FIFO result appears CMP_LAT+1 cycles after issue.
- out_rdy with out_vld=0 has no effect.
- Reset mid-operation discards in-flight and buffered results. Flags arriving after reset release with no pipe-valid are ignored.
- Results emerge in issue order.

Optional Feature:
CMP_COLLECTOR_STATS_EN
- Defined:
  - Adds input stat_clr (1).
  - Adds outputs cnt_eq, cnt_grt, cnt_lss, cnt_err (16 bits each). Each increments on push of a matching code and saturates at 16'hFFFF.
  - stat_clr zeroes all four counters and err_sticky, and takes priority over a same-cycle increment.
  - Counters reset to 0.
- Undefined: those ports and registers do not exist, and err_sticky clears only on reset.

Decomposition:
- Package cmp_collector_pkg holds:
  - typedef enum logic [1:0] cmp_code_t {CMP_EQ, CMP_GRT, CMP_LSS, CMP_ERR}
  - function classify(eq,neq,grt,lss) returning cmp_code_t
  - localparam STAT_W=16
- One sub-module, cmp_result_fifo: parameterised DEPTH/width show-ahead FIFO with push, pop, count, full and empty.
- The top level holds the delay pipe, credit logic, classification and stats.

Test Plan:
- Single issue tag=3 with flags 1000 on cycle+CMP_LAT, out_rdy=1 -> out_vld at issue+2, out_tag=3, out_code=00, fifo_cnt returns to 0.
- Burst of 8 issues with tags 0..7, alternating 0110/0101, out_rdy=0 -> issue_rdy drops after the 8th accept and stays 0. fifo_cnt=8. Then out_rdy=1 -> tags 0..7 emerge in order with codes 01,10,01,...; issue_rdy reasserts after the first pop.
- Flags 1100 for tag=5 -> out_code=11, err_sticky=1 one cycle after push and stays 1 through later valid results.
- FIFO at 4 entries with push and pop in the same cycle for 10 cycles -> fifo_cnt stays 4, no loss, ordering preserved across pointer wrap.
- Reset asserted asynchronously mid-clock with 3 in flight and 5 buffered -> outputs zero immediately. After release, stale flags 1000 produce no push and fifo_cnt=0.
- With CMP_COLLECTOR_STATS_EN, 65540 EQ results -> cnt_eq=16'hFFFF. stat_clr in the same cycle as a push -> all counters 0.

Source files
------------

// File: rtl/cmp_collector_pkg.sv
// Shared types and helpers for the comparator result collector.
// The optional statistics block is enabled with CMP_COLLECTOR_STATS_EN.
package cmp_collector_pkg;

  typedef enum logic [1:0] {
    CMP_EQ  = 2'b00,
    CMP_GRT = 2'b01,
    CMP_LSS = 2'b10,
    CMP_ERR = 2'b11
  } cmp_code_t;

  localparam int STAT_W = 16;

  // Only the three one-hot-consistent flag sets are legal; everything else is an error.
  function automatic cmp_code_t classify(input logic eq, input logic neq,
                                         input logic grt, input logic lss);
    case ({eq, neq, grt, lss})
      4'b1000: return CMP_EQ;
      4'b0110: return CMP_GRT;
      4'b0101: return CMP_LSS;
      default: return CMP_ERR;
    endcase
  endfunction

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/cmp_result_collector_if.sv
// Issue / comparator-flag / result handshake bundle of the collector.
// The master drives issues, flags and out_rdy; the collector is the slave.
interface cmp_result_collector_if #(
  parameter int TAG_W = 4
);
  logic             issue_vld;
  logic [TAG_W-1:0] issue_tag;
  logic             issue_rdy;
  logic             eq;
  logic             neq;
  logic             grt;
  logic             lss;
  logic             out_vld;
  logic             out_rdy;
  logic [TAG_W-1:0] out_tag;
  logic [1:0]       out_code;

  modport master (
    output issue_vld, issue_tag, eq, neq, grt, lss, out_rdy,
    input  issue_rdy, out_vld, out_tag, out_code
  );

  modport slave (
    input  issue_vld, issue_tag, eq, neq, grt, lss, out_rdy,
    output issue_rdy, out_vld, out_tag, out_code
  );
endinterface

// File: rtl/cmp_result_fifo.sv
// Show-ahead FIFO for tagged comparison results; head reads as zero when empty.
// Unaffected by CMP_COLLECTOR_STATS_EN.
module cmp_result_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt_q == DEPTH_CNT);
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // NOTE: storage is left unreset; validity lives in the pointers, and the head is masked when empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/cmp_result_collector.sv
// Aligns comparator flags with issued tags, classifies them and buffers results.
// Define CMP_COLLECTOR_STATS_EN to add stat_clr and saturating per-code counters.
module cmp_result_collector
  import cmp_collector_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TAG_W   = 4,
  parameter int CMP_LAT = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  cmp_result_collector_if.slave  bus,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic                   err_sticky
`ifdef CMP_COLLECTOR_STATS_EN
  ,
  input  logic                   stat_clr,
  output logic [STAT_W-1:0]      cnt_eq,
  output logic [STAT_W-1:0]      cnt_grt,
  output logic [STAT_W-1:0]      cnt_lss,
  output logic [STAT_W-1:0]      cnt_err
`endif
);
  localparam int SW = $clog2(CMP_LAT + DEPTH + 1);

  logic [CMP_LAT-1:0] pipe_vld;
  logic [TAG_W-1:0]   pipe_tag [CMP_LAT];
  logic [SW-1:0]      inflight;
  logic               issue_fire;
  logic               push;
  cmp_code_t          code;
  logic               fifo_full;
  logic               fifo_empty;

  assign issue_fire = bus.issue_vld && bus.issue_rdy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= issue_fire;
      for (int i = 1; i < CMP_LAT; i++) pipe_vld[i] <= pipe_vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pipe_tag[0] <= bus.issue_tag;
    for (int i = 1; i < CMP_LAT; i++) pipe_tag[i] <= pipe_tag[i-1];
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < CMP_LAT; i++) inflight = inflight + SW'(pipe_vld[i]);
  end

  // Credit covers both in-flight comparisons and buffered results, so a push always finds room.
  assign bus.issue_rdy = (inflight + SW'(fifo_cnt)) < SW'(DEPTH);

  assign push = pipe_vld[CMP_LAT-1];
  assign code = classify(bus.eq, bus.neq, bus.grt, bus.lss);

  cmp_result_fifo #(
    .DEPTH (DEPTH),
    .W     (TAG_W + 2)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({pipe_tag[CMP_LAT-1], code}),
    .pop       (bus.out_rdy && !fifo_empty),
    .head_data ({bus.out_tag, bus.out_code}),
    .count     (fifo_cnt),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.out_vld = !fifo_empty;

  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && fifo_full))
    else $error("result pushed into a full collector FIFO");

`ifdef CMP_COLLECTOR_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_sticky <= 1'b0;
      cnt_eq     <= '0;
      cnt_grt    <= '0;
      cnt_lss    <= '0;
      cnt_err    <= '0;
    end else if (stat_clr) begin
      err_sticky <= 1'b0;
      cnt_eq     <= '0;
      cnt_grt    <= '0;
      cnt_lss    <= '0;
      cnt_err    <= '0;
    end else if (push) begin
      case (code)
        CMP_EQ:  cnt_eq  <= sat_inc(cnt_eq);
        CMP_GRT: cnt_grt <= sat_inc(cnt_grt);
        CMP_LSS: cnt_lss <= sat_inc(cnt_lss);
        default: begin
          cnt_err    <= sat_inc(cnt_err);
          err_sticky <= 1'b1;
        end
      endcase
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         err_sticky <= 1'b0;
    else if (push && code == CMP_ERR)  err_sticky <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_cmp_result_collector.sv
// Directed plus randomized bench for cmp_result_collector against a queue-based model.
// Compile with CMP_COLLECTOR_STATS_EN to also exercise the statistics counters.
module tb_cmp_result_collector;
  localparam int DEPTH   = 8;
  localparam int TAG_W   = 4;
  localparam int CMP_LAT = 3;
  localparam int K_EQ = 0, K_GRT = 1, K_LSS = 2, K_ERR = 3;

  typedef struct {
    logic [TAG_W-1:0] tag;
    int               due;
    logic [3:0]       flags;
    logic [1:0]       code;
  } pend_t;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [1:0]       code;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  logic [$clog2(DEPTH):0] fifo_cnt;
  logic err_sticky;
`ifdef CMP_COLLECTOR_STATS_EN
  logic        stat_clr;
  logic [15:0] cnt_eq, cnt_grt, cnt_lss, cnt_err;
  int          m_cnt [4];
`endif

  cmp_result_collector_if #(.TAG_W(TAG_W)) bus ();

  cmp_result_collector #(
    .DEPTH   (DEPTH),
    .TAG_W   (TAG_W),
    .CMP_LAT (CMP_LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .fifo_cnt   (fifo_cnt),
    .err_sticky (err_sticky)
`ifdef CMP_COLLECTOR_STATS_EN
    ,
    .stat_clr   (stat_clr),
    .cnt_eq     (cnt_eq),
    .cnt_grt    (cnt_grt),
    .cnt_lss    (cnt_lss),
    .cnt_err    (cnt_err)
`endif
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  pend_t      pend_q [$];
  res_t       res_q [$];
  bit         m_err = 1'b0;
  int         cyc = 0;
  bit         idle_fixed = 1'b0;
  logic [3:0] idle_flags = 4'b0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] bad_flags();
    logic [3:0] r;
    do r = 4'($urandom_range(0, 15)); while (r == 4'b1000 || r == 4'b0110 || r == 4'b0101);
    return r;
  endfunction

  // One clock cycle: compare DUT against the model, drive inputs, advance the model at the edge.
  task automatic step(input bit iv, input logic [TAG_W-1:0] tg, input int kind,
                      input logic [3:0] ef, input bit ordy, input bit sclr);
    logic [3:0] fl;
    logic [1:0] cd;
    logic [3:0] drive_fl;
    bit         rdy_m, fire, push, pop;
    pend_t      p;
    rdy_m = (pend_q.size() + res_q.size()) < DEPTH;
    check("issue_rdy", 32'(bus.issue_rdy), 32'(rdy_m));
    check("out_vld", 32'(bus.out_vld), 32'(res_q.size() != 0));
    check("out_tag", 32'(bus.out_tag), res_q.size() != 0 ? 32'(res_q[0].tag) : 32'd0);
    check("out_code", 32'(bus.out_code), res_q.size() != 0 ? 32'(res_q[0].code) : 32'd0);
    check("fifo_cnt", 32'(fifo_cnt), 32'(res_q.size()));
    check("err_sticky", 32'(err_sticky), 32'(m_err));
`ifdef CMP_COLLECTOR_STATS_EN
    check("cnt_eq", 32'(cnt_eq), 32'(m_cnt[0]));
    check("cnt_grt", 32'(cnt_grt), 32'(m_cnt[1]));
    check("cnt_lss", 32'(cnt_lss), 32'(m_cnt[2]));
    check("cnt_err", 32'(cnt_err), 32'(m_cnt[3]));
    stat_clr = sclr;
`endif
    case (kind)
      K_EQ:    begin fl = 4'b1000; cd = 2'b00; end
      K_GRT:   begin fl = 4'b0110; cd = 2'b01; end
      K_LSS:   begin fl = 4'b0101; cd = 2'b10; end
      default: begin fl = ef;      cd = 2'b11; end
    endcase
    push = (pend_q.size() != 0) && (pend_q[0].due == cyc);
    if (push)            drive_fl = pend_q[0].flags;
    else if (idle_fixed) drive_fl = idle_flags;
    else                 drive_fl = 4'($urandom_range(0, 15));
    bus.issue_vld = iv;
    bus.issue_tag = tg;
    {bus.eq, bus.neq, bus.grt, bus.lss} = drive_fl;
    bus.out_rdy = ordy;
    @(posedge clk);
    fire = iv && rdy_m;
    pop  = ordy && (res_q.size() != 0);
    if (pop) void'(res_q.pop_front());
    if (push) begin
      p = pend_q.pop_front();
      res_q.push_back('{tag: p.tag, code: p.code});
    end
`ifdef CMP_COLLECTOR_STATS_EN
    if (sclr) begin
      m_err = 1'b0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
    end else if (push) begin
      if (p.code == 2'b11) m_err = 1'b1;
      if (m_cnt[p.code] < 65535) m_cnt[p.code]++;
    end
`else
    if (push && p.code == 2'b11) m_err = 1'b1;
`endif
    if (fire) pend_q.push_back('{tag: tg, due: cyc + CMP_LAT, flags: fl, code: cd});
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) step(1'b0, '0, K_EQ, 4'b0, ordy, 1'b0);
  endtask

  // Asserts reset between edges; outputs must clear without waiting for a clock.
  task automatic async_reset();
    bus.issue_vld = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_out_vld", 32'(bus.out_vld), 32'd0);
    check("rst_fifo_cnt", 32'(fifo_cnt), 32'd0);
    check("rst_out_tag", 32'(bus.out_tag), 32'd0);
    check("rst_out_code", 32'(bus.out_code), 32'd0);
    check("rst_err_sticky", 32'(err_sticky), 32'd0);
    pend_q.delete();
    res_q.delete();
    m_err = 1'b0;
`ifdef CMP_COLLECTOR_STATS_EN
    foreach (m_cnt[i]) m_cnt[i] = 0;
`endif
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    bus.issue_vld = 1'b0;
    bus.issue_tag = '0;
    {bus.eq, bus.neq, bus.grt, bus.lss} = 4'b0000;
    bus.out_rdy = 1'b0;
`ifdef CMP_COLLECTOR_STATS_EN
    stat_clr = 1'b0;
    foreach (m_cnt[i]) m_cnt[i] = 0;
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_issue_rdy", 32'(bus.issue_rdy), 32'd1);
    check("reset_out_vld", 32'(bus.out_vld), 32'd0);

    // Single EQ issue, tag 3: result visible CMP_LAT+1 cycles after the issue cycle.
    step(1'b1, 4'd3, K_EQ, 4'b0, 1'b1, 1'b0);
    n = 0;
    while (!bus.out_vld && n < 10) begin
      step(1'b0, '0, K_EQ, 4'b0, 1'b1, 1'b0);
      n++;
    end
    check("single_latency", 32'(n + 1), 32'(CMP_LAT + 1));
    check("single_tag", 32'(bus.out_tag), 32'd3);
    check("single_code", 32'(bus.out_code), 32'd0);
    idle(3, 1'b1);
    check("single_drained", 32'(fifo_cnt), 32'd0);

    // Burst of eight with the consumer stalled, extra issues held while credit is exhausted.
    for (int i = 0; i < 8; i++) step(1'b1, 4'(i), (i % 2 == 0) ? K_GRT : K_LSS, 4'b0, 1'b0, 1'b0);
    check("burst_rdy_low", 32'(bus.issue_rdy), 32'd0);
    for (int i = 0; i < CMP_LAT + 2; i++) step(1'b1, 4'd15, K_EQ, 4'b0, 1'b0, 1'b0);
    check("burst_full", 32'(fifo_cnt), 32'd8);
    step(1'b0, '0, K_EQ, 4'b0, 1'b1, 1'b0);
    check("burst_rdy_back", 32'(bus.issue_rdy), 32'd1);
    idle(10, 1'b1);

    // Inconsistent flags 1100 on tag 5, followed by clean results.
    step(1'b1, 4'd5, K_ERR, 4'b1100, 1'b0, 1'b0);
    idle(CMP_LAT, 1'b0);
    check("err_code", 32'(bus.out_code), 32'd3);
    check("err_tag", 32'(bus.out_tag), 32'd5);
    check("err_sticky_set", 32'(err_sticky), 32'd1);
    step(1'b1, 4'd6, K_EQ, 4'b0, 1'b1, 1'b0);
    step(1'b1, 4'd7, K_LSS, 4'b0, 1'b1, 1'b0);
    idle(CMP_LAT + 3, 1'b1);
    check("err_sticky_hold", 32'(err_sticky), 32'd1);

    // Hold four buffered entries while pushing and popping every cycle.
    n = 0;
    while (res_q.size() < 4 && n < 20) begin
      step(1'b1, 4'(n), int'($urandom_range(0, 2)), 4'b0, 1'b0, 1'b0);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 4'(n + i), int'($urandom_range(0, 2)), 4'b0, 1'b1, 1'b0);
      check("steady_cnt", 32'(fifo_cnt), 32'd4);
    end
    idle(12, 1'b1);

    // Fill to 3 in flight plus 5 buffered, then reset mid-cycle.
    n = 0;
    while (res_q.size() < 5 && n < 20) begin
      step(1'b1, 4'(n), K_GRT, 4'b0, 1'b0, 1'b0);
      n++;
    end
    check("pre_rst_inflight", 32'(pend_q.size()), 32'd3);
    async_reset();
    idle_fixed = 1'b1;
    idle_flags = 4'b1000;
    idle(CMP_LAT + 3, 1'b0);
    check("stale_flags_ignored", 32'(fifo_cnt), 32'd0);
    idle_fixed = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step(bit'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
           int'($urandom_range(0, 3)), bad_flags(), bit'($urandom_range(0, 2) != 0),
           bit'($urandom_range(0, 63) == 0));
    end
    idle(12, 1'b1);

`ifdef CMP_COLLECTOR_STATS_EN
    // Saturation of cnt_eq, then a clear that coincides with a push.
    step(1'b0, '0, K_EQ, 4'b0, 1'b1, 1'b1);
    for (int i = 0; i < 65540; i++) step(1'b1, 4'(i), K_EQ, 4'b0, 1'b1, 1'b0);
    check("cnt_eq_sat", 32'(cnt_eq), 32'h0000_FFFF);
    check("clr_push_due", 32'(pend_q.size() != 0 && pend_q[0].due == cyc), 32'd1);
    step(1'b0, '0, K_EQ, 4'b0, 1'b1, 1'b1);
    check("clr_eq", 32'(cnt_eq), 32'd0);
    check("clr_grt", 32'(cnt_grt), 32'd0);
    check("clr_lss", 32'(cnt_lss), 32'd0);
    check("clr_err", 32'(cnt_err), 32'd0);
    idle(8, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
